datamem_arbiter: RTL and testbench
==================================

# datamem_arbiter

Two-requester arbiter and sequencer for the single port of the byte-addressed data memory. Requester 0 (CPU load/store unit) and requester 1 (loader/debug port) each issue word reads and writes over a req/ack handshake. The block grants one requester at a time in round-robin order, drives the memory's address, write-data and write-enable lines, and returns registered read data. It sits between the core's data-access logic and `datamem`.

## Interface
- `MEM_SIZE`, 131072: memory size in bytes. Used for the bounds check.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `r0_req`, `r1_req`  in  1: request. Held high, with `we`/`addr`/`wdata` stable, until ack.
- `r0_we`, `r1_we`  in  1: 1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  32: byte address of the word.
- `r0_wdata`, `r1_wdata`  in  32: write data.
- `r0_ack`, `r1_ack`  out  1: one-cycle completion pulse.
- `r0_err`, `r1_err`  out  1: valid with ack. Set on an out-of-range address.
- `r0_rdata`, `r1_rdata`  out  32: read data. Valid with ack; held until the next ack to that requester.
- `mem_addr`  out  32: to memory address.
- `mem_wdata`  out  32: to memory write data.
- `mem_wen`  out  1: to memory write enable.
- `mem_dout`  in  32: combinational read data from memory.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If any req is high, pick a winner.
  - Winner is the requester not granted last. A lone requester always wins.
  - Latch the winner's id, we, addr and wdata into internal registers, update the last-grant pointer, and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (exactly one cycle)
  - `mem_addr` and `mem_wdata` come from the latches.
  - Range check: error if addr > MEM_SIZE-4 (full 32-bit compare, no wrap).
  - Write, no error: `mem_wen`=1, so the memory writes on the closing edge.
  - Read, no error: `mem_dout` is captured into the winner's rdata register on the closing edge.
  - Error: `mem_wen`=0, and the winner's rdata is loaded with 0.
  - Go to RESP.
- **RESP** (one cycle)
  - Winner's ack=1, and its err = the latched error flag.
  - Go to IDLE.
- Ack/err to the non-winner stays 0.
- A requester still holding req in the cycle after RESP is treated as a new request and re-arbitrated.
- `mem_wen` is 1 only in ACCESS for a non-error write; it is decoded from state and latches.
- In IDLE and RESP, `mem_addr` holds the last latched address and `mem_wen`=0.
- Alignment is not checked. Data passes through unchanged, with no byte swapping.
- Reset, asynchronous and effective at any point:
  - State goes to IDLE and the last-grant pointer points to requester 1, so requester 0 wins the first tie.
  - `mem_wen`, all acks and errs = 0.
  - rdata registers, `mem_addr` and `mem_wdata` = 0.
- Reset during ACCESS aborts the access: `mem_wen` drops immediately and no ack is issued.

## Timing
- Latency is 3 cycles from the edge sampling req in IDLE to the ack cycle:
  - edge E0: grant, enter ACCESS;
  - edge E1: memory write or read capture, enter RESP;
  - ack is high between E1 and E2.
- Throughput is one access per 3 cycles. Arbitration happens only in IDLE.
- With both requesters continuously requesting, grants alternate 0,1,0,1 with a 3-cycle spacing.
- Requests arriving during ACCESS or RESP wait. No request is dropped while req stays high.
- A requester may drop req before ack only if not yet granted. Dropping req after grant does not cancel the access.

## Test plan
- **Reset values.** Assert `rst` mid-cycle with `r0_req`=1 → all acks/errs/`mem_wen` immediately 0, rdata=0. Release → first grant to r0.
- **Write then read, r0.** Write addr 0x100, data 0xDEADBEEF → `mem_wen`=1 for exactly one cycle, with `mem_addr`=0x100. Then read 0x100 → `r0_ack` 3 cycles after req, with `r0_rdata`=0xDEADBEEF and `r0_err`=0.
- **Contention.** Both reqs held high for 12 cycles (r0 read 0x0, r1 read 0x4) → acks at cycles 3,6,9,12 alternating r0,r1,r0,r1. Ack and err never high for the non-winner.
- **Bounds.**
  - r1 write at addr 131068 (MEM_SIZE-4) → normal write, err=0.
  - r1 write at 131069 → `mem_wen` stays 0, `r1_err`=1 with ack, `r1_rdata`=0.
  - Read at 0xFFFFFFFE → err=1.
- **Reset mid-ACCESS.** r0 write to 0x200, `rst` pulsed during ACCESS → no ack, memory at 0x200 unchanged. After release, a re-request completes normally.
- **Rdata hold / re-request.** r1 reads 0x10 (value 0x12345678) and keeps req high → a second ack follows 3 cycles after the first. `r0_rdata` stays unchanged throughout.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter and sequencer for the data memory's single port.
// Two requesters share it over a req/ack handshake; each access takes IDLE -> ACCESS -> RESP.
module datamem_arbiter #(
    parameter int unsigned MEM_SIZE = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_dout
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_SIZE - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          win_id;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic          addr_err;
    logic          grant_c;

    // The requester not granted last wins a tie; a lone requester always wins.
    assign grant_c  = (r0_req && r1_req) ? ~last_grant : r1_req;
    assign addr_err = lat_addr > ADDR_MAX;

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    // Decoded from state so an async reset in ACCESS drops the write at once.
    assign mem_wen   = (state == ACCESS) && lat_we && !addr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
        end else begin
            r0_ack <= 1'b0;
            r0_err <= 1'b0;
            r1_ack <= 1'b0;
            r1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        win_id     <= grant_c;
                        last_grant <= grant_c;
                        lat_we     <= grant_c ? r1_we    : r0_we;
                        lat_addr   <= grant_c ? r1_addr  : r0_addr;
                        lat_wdata  <= grant_c ? r1_wdata : r0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Reads capture memory data; rejected accesses clear rdata.
                    if (addr_err || !lat_we) begin
                        if (win_id) r1_rdata <= addr_err ? '0 : mem_dout;
                        else        r0_rdata <= addr_err ? '0 : mem_dout;
                    end
                    if (win_id) begin
                        r1_ack <= 1'b1;
                        r1_err <= addr_err;
                    end else begin
                        r0_ack <= 1'b1;
                        r0_err <= addr_err;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard bench for datamem_arbiter: directed scenarios plus random traffic
// from both requesters, checked against a word-level memory model.
module tb_datamem_arbiter;

    localparam int unsigned MEM_SIZE = 131072;
    localparam logic [31:0] ADDR_MAX = 32'(MEM_SIZE - 4);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we, r0_ack, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_ack, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_dout;
    logic        mem_wen;

    logic [31:0] mem [0:32767];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] pend_wr [logic [31:0]];
    logic [31:0] last_rdata [2];
    logic [31:0] mon_rdata [2];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          ack_log [$];
    logic        wen_prev;

    int n_checks;
    int n_fail;

    datamem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_ack   (r0_ack),
        .r0_err   (r0_err),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_ack   (r1_ack),
        .r1_err   (r1_err),
        .r1_rdata (r1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: combinational read, write on the rising edge.
    assign mem_dout = mem[mem_addr[16:2]];
    always @(posedge clk) if (mem_wen) mem[mem_addr[16:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic set_port(input int id, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Reference model: outcome of one transaction from the memory rules alone.
    task automatic model_issue(input int id, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.err = (addr > ADDR_MAX);
        if (e.err) begin
            e.rdata = '0;
        end else if (we) begin
            ref_mem[addr] = wdata;
            pend_wr[addr] = wdata;
            e.rdata = last_rdata[id];
        end else begin
            e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        end
        last_rdata[id] = e.rdata;
        if (id == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
    endtask

    task automatic do_req(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        logic ack_now;
        model_issue(id, we, addr, wdata);
        set_port(id, 1'b1, we, addr, wdata);
        lat = 0;
        ack_now = 1'b0;
        while (!ack_now && lat < 50) begin
            @(negedge clk);
            lat++;
            ack_now = (id == 0) ? r0_ack : r1_ack;
        end
        if (!ack_now) chk("ack_timeout", 32'(ack_now), 32'd1);
        set_port(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic reset_dut();
        #2 rst = 1'b1;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic mon_port(input int id, input logic ack, input logic err, input logic [31:0] rdata);
        exp_t e;
        if (ack) begin
            if ((id == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                chk($sformatf("spurious_ack%0d", id), 32'(ack), 32'd0);
            end else begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("err%0d", id), 32'(err), 32'(e.err));
                chk($sformatf("rdata%0d", id), rdata, e.rdata);
                mon_rdata[id] = e.rdata;
                ack_log.push_back(id);
            end
        end else begin
            chk($sformatf("idle_err%0d", id), 32'(err), 32'd0);
            chk($sformatf("rdata_hold%0d", id), rdata, mon_rdata[id]);
        end
    endtask

    // Monitor: pops expectations on every ack and audits every memory write.
    always @(negedge clk) begin
        if (rst) begin
            mon_rdata[0] = '0;
            mon_rdata[1] = '0;
            wen_prev = 1'b0;
        end else begin
            chk("dual_ack", 32'(r0_ack & r1_ack), 32'd0);
            mon_port(0, r0_ack, r0_err, r0_rdata);
            mon_port(1, r1_ack, r1_err, r1_rdata);
            if (mem_wen) begin
                chk("wen_run", 32'(wen_prev), 32'd0);
                if (pend_wr.exists(mem_addr)) begin
                    chk("wr_data", mem_wdata, pend_wr[mem_addr]);
                    pend_wr.delete(mem_addr);
                end else begin
                    chk("wr_unexpected", 32'(mem_wen), 32'd0);
                end
            end
            wen_prev = mem_wen;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, k1, k2;
        logic [31:0] old_val;
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        mon_rdata[0] = '0;
        mon_rdata[1] = '0;
        wen_prev = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Write then read back from requester 0, from idle.
        @(negedge clk);
        do_req(0, 1'b1, 32'h100, 32'hDEADBEEF, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        @(negedge clk);
        do_req(0, 1'b0, 32'h100, 32'h0, lat);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_value", r0_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(r0_err), 32'd0);

        // Reset mid-cycle while ack is high and r0 requests.
        set_port(0, 1'b1, 1'b0, 32'h100, 32'h0);
        #2 rst = 1'b1;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        #1;
        chk("rst_r0_ack", 32'(r0_ack), 32'd0);
        chk("rst_r0_err", 32'(r0_err), 32'd0);
        chk("rst_r1_ack", 32'(r1_ack), 32'd0);
        chk("rst_r1_err", 32'(r1_err), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'h0);
        chk("rst_r1_rdata", r1_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        ack_log.delete();
        fork
            begin int l0; do_req(0, 1'b0, 32'h100, 32'h0, l0); end
            begin int l1; do_req(1, 1'b0, 32'h10004, 32'h0, l1); end
        join
        chk("first_grant_r0", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd0);

        // Contention: both requesters hold req for 12 cycles after a fresh reset.
        @(negedge clk);
        do_req(0, 1'b1, 32'h0, 32'hA5A5_0000, lat);
        @(negedge clk);
        do_req(1, 1'b1, 32'h4, 32'h5A5A_0004, lat);
        reset_dut();
        model_issue(0, 1'b0, 32'h0, 32'h0);
        model_issue(0, 1'b0, 32'h0, 32'h0);
        model_issue(1, 1'b0, 32'h4, 32'h0);
        model_issue(1, 1'b0, 32'h4, 32'h0);
        set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("cont_r0_ack_c%0d", c), 32'(r0_ack), 32'((c == 2) || (c == 8)));
            chk($sformatf("cont_r1_ack_c%0d", c), 32'(r1_ack), 32'((c == 5) || (c == 11)));
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Bounds around the top of memory.
        @(negedge clk);
        do_req(1, 1'b1, ADDR_MAX, 32'hCAFEF00D, lat);
        chk("bound_max_err", 32'(r1_err), 32'd0);
        do_req(1, 1'b0, ADDR_MAX, 32'h0, lat);
        chk("bound_max_rd", r1_rdata, 32'hCAFEF00D);
        do_req(1, 1'b1, ADDR_MAX + 32'd1, 32'h11111111, lat);
        chk("bound_over_err", 32'(r1_err), 32'd1);
        chk("bound_over_rdata", r1_rdata, 32'h0);
        do_req(0, 1'b0, 32'hFFFF_FFFE, 32'h0, lat);
        chk("bound_top_err", 32'(r0_err), 32'd1);

        // Reset pulsed during ACCESS aborts the write.
        repeat (2) @(negedge clk);
        old_val = mem[32'h200 >> 2];
        pend_wr[32'h200] = 32'h77777777;
        set_port(0, 1'b1, 1'b1, 32'h200, 32'h77777777);
        @(negedge clk);
        chk("abort_wen_pre", 32'(mem_wen), 32'd1);
        #2 rst = 1'b1;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        #1;
        chk("abort_wen_drop", 32'(mem_wen), 32'd0);
        chk("abort_ack", 32'(r0_ack), 32'd0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_mem", mem[32'h200 >> 2], old_val);
        do_req(0, 1'b1, 32'h200, 32'h77777777, lat);
        chk("rereq_mem", mem[32'h200 >> 2], 32'h77777777);

        // r1 keeps req high and is re-arbitrated.
        @(negedge clk);
        do_req(0, 1'b1, 32'h10, 32'h12345678, lat);
        @(negedge clk);
        model_issue(1, 1'b0, 32'h10, 32'h0);
        model_issue(1, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h10, 32'h0);
        k = 0; k1 = -1; k2 = -1;
        while (k < 20 && k2 < 0) begin
            @(negedge clk);
            k++;
            if (r1_ack) begin
                if (k1 < 0) k1 = k;
                else        k2 = k;
            end
        end
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hold_first_lat", 32'(k1), 32'd2);
        chk("hold_gap", 32'(k2 - k1), 32'd3);
        chk("hold_r1_rdata", r1_rdata, 32'h12345678);

        // Random traffic: each requester in its own address region.
        fork
            begin
                int l;
                logic [31:0] a;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if ($urandom_range(0, 7) == 0) a = 32'd131069 + 32'($urandom_range(0, 32'h7FFF_FFFF));
                    else                           a = 32'($urandom_range(0, 1023)) << 2;
                    do_req(0, 1'($urandom_range(0, 1)), a, $urandom, l);
                end
            end
            begin
                int l;
                logic [31:0] a;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if ($urandom_range(0, 7) == 0) a = 32'd131069 + 32'($urandom_range(0, 32'h7FFF_FFFF));
                    else                           a = 32'h10000 + (32'($urandom_range(0, 16383)) << 2);
                    do_req(1, 1'($urandom_range(0, 1)), a, $urandom, l);
                end
            end
        join

        repeat (4) @(negedge clk);
        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
        chk("writes_drained", 32'(pend_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
